// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared datapath width, FSM state type and ALU function codes
package alu_arb_pkg;
  localparam int ALU_W = 32;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: 32-bit ALU where f[2] inverts b and f[1:0] picks AND/OR/SUM/SLT
module alu_arbiter_alu import alu_arb_pkg::*; (
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [2:0]       f_i,
  output logic [ALU_W-1:0] y_o,
  output logic             z_o
);
  logic [ALU_W-1:0] bb, s;
  // invert b and add the carry-in for SUB/SLT, then select logic, sum or sign result
  always_comb begin
    bb  = f_i[2] ? ~b_i : b_i;
    s   = a_i + bb + {{(ALU_W-1){1'b0}}, f_i[2]};
    y_o = f_i[1:0] == F_AND[1:0] ? a_i & bb :
          f_i[1:0] == F_OR[1:0]  ? a_i | bb :
          f_i[1:0] == F_ADD[1:0] ? s : {{(ALU_W-1){1'b0}}, s[ALU_W-1]};
    z_o = y_o == '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of N_REQ requesters onto one shared ALU
module alu_arbiter import alu_arb_pkg::*; #(
  parameter int N_REQ = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][ALU_W-1:0] req_a,
  input  logic [N_REQ-1:0][ALU_W-1:0] req_b,
  input  logic [N_REQ-1:0][2:0]       req_f,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic [ALU_W-1:0]            rsp_y,
  output logic                        rsp_z,
  output logic                        busy,
  output logic [15:0]                 op_count
);
  localparam int GW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  state_t           state_q;
  logic [GW-1:0]    last_q, grant_q, g_d, k;
  logic             hit;
  logic [ALU_W-1:0] a_q, b_q, y_q, alu_y;
  logic [2:0]       f_q;
  logic             z_q, alu_z;
  logic [15:0]      op_cnt_q;
  alu_arbiter_alu u_alu (
    .a_i (a_q),
    .b_i (b_q),
    .f_i (f_q),
    .y_o (alu_y),
    .z_o (alu_z)
  );
  // first valid requester searching upward from the one after the last completed grant
  always_comb begin
    hit = 1'b0;
    g_d = last_q;
    k   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = GW'((int'(last_q) + i) % N_REQ);
      if (!hit && req_valid[k]) begin
        hit = 1'b1;
        g_d = k;
      end
    end
  end
  assign req_ready = (rst_n && state_q == IDLE && hit) ? ONE << g_d : '0;
  assign rsp_valid = (rst_n && state_q == RESP) ? ONE << grant_q : '0;
  assign rsp_y     = rst_n ? y_q : '0;
  assign rsp_z     = rst_n & z_q;
  assign busy      = rst_n && state_q != IDLE;
  assign op_count  = op_cnt_q;
  // accept a request, run it through the ALU, then hold the result until the grantee takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= GW'(N_REQ - 1);
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      y_q      <= '0;
      z_q      <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (hit) begin
          grant_q <= g_d;
          a_q     <= req_a[g_d];
          b_q     <= req_b[g_d];
          f_q     <= req_f[g_d];
          state_q <= EXEC;
        end
        EXEC: begin
          y_q     <= alu_y;
          z_q     <= alu_z;
          state_q <= RESP;
        end
        RESP: if (rsp_ready[grant_q]) begin
          last_q   <= grant_q;
          op_cnt_q <= op_cnt_q + 16'd1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
